vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; next generation of the display controller.

---
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/vga_timing_gen.sv | 113 +++++++++++
 tb/tb_vga_timing_gen.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumer.
//   pixelEn, enable      : pixel tick and run/freeze, driven by the consumer side
//   column, row          : current raster count
//   hSync, vSync         : sync outputs at their configured polarity
//   displayActive        : visible-area flag, aligned with the syncs
//   lineStart/frameStart : one-clock strobes aligned with column/row
// master = the timing generator, slave = whoever drives the ticks and consumes timing.
interface vga_timing_gen_if #(
  parameter int COL_W = 10,
  parameter int ROW_W = 10
);
  logic             pixelEn;
  logic             enable;
  logic [COL_W-1:0] column;
  logic [ROW_W-1:0] row;
  logic             hSync;
  logic             vSync;
  logic             displayActive;
  logic             lineStart;
  logic             frameStart;

  modport master (
    input  pixelEn, enable,
    output column, row, hSync, vSync, displayActive, lineStart, frameStart
  );

  modport slave (
    output pixelEn, enable,
    input  column, row, hSync, vSync, displayActive, lineStart, frameStart
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator on the system clock with a pixel-tick enable.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : vga_timing_gen_if.master (pixelEn/enable in; counts, syncs, active, strobes out)
// The count advances on pixelEn & enable. hSync/vSync/displayActive lag the count by
// PIPE_DELAY pixel ticks so they line up with a colour path of the same latency.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int PIPE_DELAY = 1,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 10
) (
  input  logic           clk,
  input  logic           rst,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // A zero-delay build still needs one register so the outputs stay glitch-free.
  localparam int DEPTH   = (PIPE_DELAY == 0) ? 1 : PIPE_DELAY;

  localparam logic [COL_W-1:0] H_LAST  = COL_W'(H_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_LAST  = ROW_W'(V_TOTAL - 1);
  localparam logic [COL_W-1:0] H_ACT   = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0] V_ACT   = ROW_W'(V_ACTIVE);
  localparam logic [COL_W-1:0] HS_BEG  = COL_W'(H_ACTIVE + H_FP);
  localparam logic [COL_W-1:0] HS_END  = COL_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [ROW_W-1:0] VS_BEG  = ROW_W'(V_ACTIVE + V_FP);
  localparam logic [ROW_W-1:0] VS_END  = ROW_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      PIPE_DELAY < 0 || PIPE_DELAY > 7 ||
      H_TOTAL > (1 << COL_W) || V_TOTAL > (1 << ROW_W)) begin : g_param_chk
    $error("vga_timing_gen: illegal parameter set");
  end

  // Logical (polarity-free) timing flags; polarity is applied only at the pins.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } tuple_t;

  function automatic tuple_t decode(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    tuple_t t;
    t.hs  = (c >= HS_BEG) && (c <= HS_END);
    t.vs  = (r >= VS_BEG) && (r <= VS_END);
    t.act = (c < H_ACT) && (r < V_ACT);
    return t;
  endfunction

  logic [COL_W-1:0]        col_q, col_d, col_nxt;
  logic [ROW_W-1:0]        row_q, row_d, row_nxt;
  tuple_t [DEPTH-1:0]      pipe_q, pipe_d;
  tuple_t                  head;
  logic                    line_q, line_d, frame_q, frame_d;
  logic                    adv;

  always_comb begin
    adv     = bus.pixelEn & bus.enable;
    col_nxt = (col_q == H_LAST) ? '0 : col_q + COL_W'(1);
    row_nxt = row_q;
    if (col_q == H_LAST) row_nxt = (row_q == V_LAST) ? '0 : row_q + ROW_W'(1);

    col_d   = adv ? col_nxt : col_q;
    row_d   = adv ? row_nxt : row_q;
    // Strobes are raised for the cycle that shows the wrapped count, then drop.
    line_d  = adv && (col_q == H_LAST);
    frame_d = line_d && (row_q == V_LAST);

    // Zero delay registers the decode of the count about to be shown; otherwise the
    // count being left enters the shift register, giving exactly PIPE_DELAY ticks of lag.
    head   = (PIPE_DELAY == 0) ? decode(row_nxt, col_nxt) : decode(row_q, col_q);
    pipe_d = pipe_q;
    if (adv) begin
      pipe_d[0] = head;
      for (int k = 1; k < DEPTH; k++) pipe_d[k] = pipe_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      pipe_q  <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      pipe_q  <= pipe_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign bus.column        = col_q;
  assign bus.row           = row_q;
  assign bus.hSync         = pipe_q[DEPTH-1].hs ? H_POL : ~H_POL;
  assign bus.vSync         = pipe_q[DEPTH-1].vs ? V_POL : ~V_POL;
  assign bus.displayActive = pipe_q[DEPTH-1].act;
  assign bus.lineStart     = line_q;
  assign bus.frameStart    = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster (15 x 9 ticks per frame).
// Two instances share the stimulus: PIPE_DELAY=0 with active-low syncs, and
// PIPE_DELAY=3 with active-high syncs. The reference model counts pixel ticks since
// reset and derives everything from that number with plain arithmetic.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 5, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int CW = 4, RW = 4;

  logic clk = 1'b0;
  logic rst, pix, en;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.COL_W(CW), .ROW_W(RW)) if0 ();
  vga_timing_gen_if #(.COL_W(CW), .ROW_W(RW)) if3 ();
  assign if0.pixelEn = pix;
  assign if0.enable  = en;
  assign if3.pixelEn = pix;
  assign if3.enable  = en;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(0), .COL_W(CW), .ROW_W(RW)
  ) dut0 (.clk(clk), .rst(rst), .bus(if0.master));

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(3), .COL_W(CW), .ROW_W(RW)
  ) dut3 (.clk(clk), .rst(rst), .bus(if3.master));

  typedef struct packed {
    int col;
    int row;
    bit hs0, vs0, act0;
    bit hs3, vs3, act3;
    bit ls, fs;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   n      = 0;   // pixel ticks since reset release
  bit   ls_m   = 1'b0;
  bit   fs_m   = 1'b0;

  // Timing flags of the raster position reached after t ticks; t < 0 means "no
  // position yet", which shows as the inactive tuple.
  function automatic void dec(input int t, output bit h, output bit v, output bit a);
    int c, r;
    h = 1'b0; v = 1'b0; a = 1'b0;
    if (t >= 0) begin
      c = t % HT;
      r = (t / HT) % VT;
      h = (c >= HA + HF) && (c < HA + HF + HS);
      v = (r >= VA + VF) && (r < VA + VF + VS);
      a = (c < HA) && (r < VA);
    end
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    bit h, v, a;
    e.col = n % HT;
    e.row = (n / HT) % VT;
    // Zero delay: outputs keep reset values until the first tick after reset.
    dec((n == 0) ? -1 : n, h, v, a);
    e.hs0 = ~h; e.vs0 = ~v; e.act0 = a;
    dec(n - 3, h, v, a);
    e.hs3 = h;  e.vs3 = v;  e.act3 = a;
    e.ls  = ls_m;
    e.fs  = fs_m;
    return e;
  endfunction

  // One clock: account for the edge just taken with the held inputs, then drive new ones.
  task automatic step(input bit nrst, input bit npix, input bit nen);
    @(posedge clk);
    #1;
    if (rst && pix && en) begin
      n++;
      ls_m = (n % HT == 0);
      fs_m = (n % FT == 0);
    end else begin
      ls_m = 1'b0;
      fs_m = 1'b0;
    end
    rst = nrst; pix = npix; en = nen;
    if (!nrst) begin
      n = 0; ls_m = 1'b0; fs_m = 1'b0;
    end
    sbq.push_back(expect_now());
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("column0",  int'(if0.column),        e.col);
      chk("row0",     int'(if0.row),           e.row);
      chk("column3",  int'(if3.column),        e.col);
      chk("row3",     int'(if3.row),           e.row);
      chk("hsync0",   int'(if0.hSync),         int'(e.hs0));
      chk("vsync0",   int'(if0.vSync),         int'(e.vs0));
      chk("active0",  int'(if0.displayActive), int'(e.act0));
      chk("hsync3",   int'(if3.hSync),         int'(e.hs3));
      chk("vsync3",   int'(if3.vSync),         int'(e.vs3));
      chk("active3",  int'(if3.displayActive), int'(e.act3));
      chk("line0",    int'(if0.lineStart),     int'(e.ls));
      chk("frame0",   int'(if0.frameStart),    int'(e.fs));
      chk("line3",    int'(if3.lineStart),     int'(e.ls));
      chk("frame3",   int'(if3.frameStart),    int'(e.fs));
    end
  end

  initial begin
    int guard;
    rst = 1'b0; pix = 1'b0; en = 1'b0;

    // Held in reset with the tick toggling.
    for (int i = 0; i < 8; i++) step(1'b0, i[0], 1'b1);

    // Release; tick on every second clock for two frames and a bit.
    for (int i = 0; i < 4 * FT + 10; i++) step(1'b1, i[0], 1'b1);

    // Random tick gaps and enable drops.
    for (int i = 0; i < 2500; i++) step(1'b1, ($urandom % 4) != 0, ($urandom % 16) != 0);

    // Freeze for 50 clocks in the middle of horizontal sync, then resume.
    guard = 0;
    while ((n % HT) != HA + HF + 1 && guard < 2 * HT) begin
      step(1'b1, 1'b1, 1'b1);
      guard++;
    end
    for (int i = 0; i < 50; i++) step(1'b1, ($urandom % 2) != 0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a line and frame, then restart.
    guard = 0;
    while (!(((n / HT) % VT) == 3 && (n % HT) == 5) && guard < 2 * FT) begin
      step(1'b1, 1'b1, 1'b1);
      guard++;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 1000; i++) step(1'b1, ($urandom % 3) != 0, ($urandom % 20) != 0);

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
